// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data memory.
// Port 0 is the pipeline load/store stage, port 1 the secondary master.
// A locked request can hold the memory for at most BURST_MAX cycles.
// Read data from the memory is routed back to the port that issued the read.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | free arbitration, both ports eligible, ties go to port != last
// ST_OWN0  | port 0 holds the memory under lock, port 1 blocked
// ST_OWN1  | port 1 holds the memory under lock, port 0 blocked
module dmem_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_MAX  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,
   input  logic                  req0_lock,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,
   input  logic                  req1_lock,
   output logic                  req1_ready,
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam int CW = $clog2(BURST_MAX) + 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN0 = 2'd1;
   localparam logic [1:0] ST_OWN1 = 2'd2;

   logic [1:0]    state;
   logic          last;
   logic [CW-1:0] burst_cnt;
   logic [1:0]    rsp_pend;

   logic gnt0;
   logic gnt1;
   logic xfer;
   logic gnt_lock;
   logic owner;
   logic burst_end;

   // Grant decision: ownership restricts eligibility, otherwise round-robin on ties.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state)
         ST_IDLE: begin
            if (req0_valid && req1_valid) begin
               gnt0 = last;
               gnt1 = !last;
            end else begin
               gnt0 = req0_valid;
               gnt1 = req1_valid;
            end
         end
         ST_OWN0: gnt0 = req0_valid;
         ST_OWN1: gnt1 = req1_valid;
         default: begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
         end
      endcase
      if (rst) begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign xfer       = gnt0 | gnt1;
   assign gnt_lock   = (gnt0 & req0_lock) | (gnt1 & req1_lock);
   assign owner      = (state == ST_OWN1);
   assign burst_end  = (burst_cnt == CW'(BURST_MAX - 1));

   // Memory request mux: granted port's fields, zero when no transfer.
   always_comb begin
      mem_en    = xfer;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (gnt0) begin
         mem_we    = req0_we;
         mem_addr  = req0_addr;
         mem_wdata = req0_wdata;
      end else if (gnt1) begin
         mem_we    = req1_we;
         mem_addr  = req1_addr;
         mem_wdata = req1_wdata;
      end
   end

   // Read data goes only to the port whose read was accepted last cycle.
   always_comb begin
      rsp0_valid = rsp_pend[0] & !rst;
      rsp1_valid = rsp_pend[1] & !rst;
      rsp0_rdata = rsp0_valid ? mem_rdata : '0;
      rsp1_rdata = rsp1_valid ? mem_rdata : '0;
   end

   // Arbitration state, lock ownership and burst length tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         last      <= 1'b1;
         burst_cnt <= '0;
         rsp_pend  <= 2'b00;
      end else begin
         rsp_pend <= {gnt1 & !req1_we, gnt0 & !req0_we};
         case (state)
            ST_IDLE: begin
               if (xfer) begin
                  last <= gnt1;
                  if (gnt_lock) begin
                     state     <= gnt1 ? ST_OWN1 : ST_OWN0;
                     burst_cnt <= CW'(1);
                  end
               end
            end
            ST_OWN0, ST_OWN1: begin
               // Idle owner cycles still count, so a stalled owner cannot hold forever.
               if (burst_end || (xfer && !gnt_lock)) begin
                  state     <= ST_IDLE;
                  burst_cnt <= '0;
                  last      <= owner;
               end else begin
                  burst_cnt <= burst_cnt + CW'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               burst_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle expected grants, read responses
// predicted into a queue at grant time and checked one cycle later.
module tb_dmem_arbiter;

   localparam int DW   = 64;
   localparam int AW   = 32;
   localparam int BMAX = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req0_valid = 1'b0, req0_we = 1'b0, req0_lock = 1'b0;
   logic [AW-1:0] req0_addr = '0;
   logic [DW-1:0] req0_wdata = '0;
   logic          req1_valid = 1'b0, req1_we = 1'b0, req1_lock = 1'b0;
   logic [AW-1:0] req1_addr = '0;
   logic [DW-1:0] req1_wdata = '0;
   logic          req0_ready, req1_ready;
   logic          rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp0_rdata, rsp1_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int            port;
      logic [DW-1:0] data;
   } rsp_t;
   rsp_t exp_q[$];

   dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_MAX(BMAX)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_lock(req0_lock), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_lock(req1_lock), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
      return (a == 32'h10) ? 64'hDEAD : {~a, a};
   endfunction

   // Memory model: 1-cycle read latency, garbage when no read was issued.
   always @(posedge clk) begin
      if (mem_en && !mem_we) mem_rdata <= mem_val(mem_addr);
      else                   mem_rdata <= 64'hBAD0_BAD0_BAD0_BAD0;
   end

   task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // One cycle: drive requests, check response from last cycle and this cycle's grant.
   // g: 0 = port0 granted, 1 = port1 granted, 2 = no grant.
   task automatic cyc(input logic v0, input logic l0, input logic w0, input logic [AW-1:0] a0,
                      input logic v1, input logic l1, input logic w1, input logic [AW-1:0] a1,
                      input int g);
      rsp_t e;
      logic ev0, ev1;
      logic [DW-1:0] ed;
      @(negedge clk);
      rst = 1'b0;
      req0_valid = v0; req0_lock = l0; req0_we = w0; req0_addr = a0;
      req0_wdata = {32'hC0DE_0000, a0};
      req1_valid = v1; req1_lock = l1; req1_we = w1; req1_addr = a1;
      req1_wdata = {32'h5EC0_0000, a1};
      #1;
      ev0 = 1'b0; ev1 = 1'b0; ed = '0;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         ev0 = (e.port == 0);
         ev1 = (e.port == 1);
         ed  = e.data;
      end
      chk("rsp0_valid", rsp0_valid, ev0);
      chk("rsp1_valid", rsp1_valid, ev1);
      chk("rsp0_rdata", rsp0_rdata, ev0 ? ed : '0);
      chk("rsp1_rdata", rsp1_rdata, ev1 ? ed : '0);
      chk("req0_ready", req0_ready, g == 0);
      chk("req1_ready", req1_ready, g == 1);
      chk("mem_en", mem_en, g != 2);
      if (g == 0) begin
         chk("mem_we", mem_we, w0);
         chk("mem_addr", mem_addr, a0);
         if (w0) chk("mem_wdata", mem_wdata, {32'hC0DE_0000, a0});
         else    exp_q.push_back('{0, mem_val(a0)});
      end else if (g == 1) begin
         chk("mem_we", mem_we, w1);
         chk("mem_addr", mem_addr, a1);
         if (w1) chk("mem_wdata", mem_wdata, {32'h5EC0_0000, a1});
         else    exp_q.push_back('{1, mem_val(a1)});
      end else begin
         chk("mem_we_idle", mem_we, 1'b0);
         chk("mem_addr_idle", mem_addr, '0);
      end
   endtask

   // Reset cycle with both ports requesting: everything must stay quiet.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req0_valid = 1'b1; req0_lock = 1'b1; req0_we = 1'b1; req0_addr = 32'hFF0;
      req1_valid = 1'b1; req1_lock = 1'b1; req1_we = 1'b1; req1_addr = 32'hFF1;
      #1;
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_ready1", req1_ready, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_rsp0_valid", rsp0_valid, 1'b0);
      chk("rst_rsp1_valid", rsp1_valid, 1'b0);
      exp_q.delete();
   endtask

   initial begin
      do_reset();
      do_reset();

      // Single read from port 0, response one cycle later.
      cyc(1, 0, 0, 32'h10, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 2);

      // Both ports reading every cycle: strict alternation, port 1 first (last=0).
      for (int i = 0; i < 6; i++)
         cyc(1, 0, 0, 32'h100 + i, 1, 0, 0, 32'h200 + i, (i % 2 == 0) ? 1 : 0);

      // Port 0 write: no response afterwards.
      cyc(1, 0, 1, 32'h20, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 2);

      // Port 1 locks for 3 transfers, releases on the 4th; port 0 waits then wins.
      for (int i = 0; i < 4; i++)
         cyc(1, 0, 0, 32'h30, 1, (i < 3), 0, 32'h300 + i, 1);
      cyc(1, 0, 0, 32'h30, 0, 0, 0, 0, 0);

      // Lock held throughout: forced release after BMAX grants.
      for (int i = 0; i < BMAX; i++)
         cyc(1, 0, 0, 32'h40, 1, 1, (i % 3 == 1), 32'h400 + i, 1);
      cyc(1, 0, 0, 32'h40, 1, 1, 0, 32'h480, 0);

      // Owner goes idle: its idle cycles still run out the burst.
      cyc(0, 0, 0, 0, 1, 1, 0, 32'h500, 1);
      for (int i = 0; i < BMAX - 1; i++)
         cyc(1, 0, 0, 32'h50, 0, 0, 0, 0, 2);
      cyc(1, 0, 0, 32'h50, 0, 0, 0, 0, 0);

      // Reset while port 1 owns a lock with a read pending.
      cyc(0, 0, 0, 0, 1, 1, 0, 32'h600, 1);
      cyc(1, 0, 0, 32'h60, 1, 1, 0, 32'h601, 1);
      do_reset();
      cyc(1, 0, 0, 32'h70, 1, 0, 0, 32'h700, 0);
      cyc(1, 0, 0, 32'h71, 1, 0, 0, 32'h701, 1);
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 2);

      // Reset right after an accepted port 0 read discards its response.
      cyc(1, 0, 0, 32'h80, 0, 0, 0, 0, 0);
      do_reset();
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
